// File: rtl/adc_frame_scheduler.sv
// adc_frame_scheduler
// Moves the three ADC control words from the SPI receiver into the i_clock
// domain. The frame-done flag is resynchronised and edge-detected. After a
// settle window the words are range-checked and captured into a pending
// buffer. The pending frame is applied to the outputs only on an audio
// sample tick, so control values never change mid-sample.
//
// Ports:
//   i_clock, i_reset          system clock, synchronous active-high reset
//   i_data_received           frame-done flag (asynchronous to i_clock)
//   i_data0..i_data2          frame words, stable while the flag is high
//   i_sample_tick             one-cycle strobe per audio sample
//   i_clear_flags             clears o_overrun and o_frame_errors
//   o_ctrl0..o_ctrl2          applied control words
//   o_update                  one-cycle pulse when o_ctrl* change
//   o_pending                 a captured frame waits for a tick
//   o_overrun                 sticky: a frame was lost or overwritten
//   o_frame_errors            saturating count of rejected frames
//   o_stale                   no accepted frame within TIMEOUT_CYCLES
module adc_frame_scheduler #(
    parameter int SYNC_STAGES    = 2,
    parameter int SETTLE_CYCLES  = 4,
    parameter int ADC_BITS       = 12,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_data_received,
    input  logic [15:0] i_data0,
    input  logic [15:0] i_data1,
    input  logic [15:0] i_data2,
    input  logic        i_sample_tick,
    input  logic        i_clear_flags,
    output logic [15:0] o_ctrl0,
    output logic [15:0] o_ctrl1,
    output logic [15:0] o_ctrl2,
    output logic        o_update,
    output logic        o_pending,
    output logic        o_overrun,
    output logic [7:0]  o_frame_errors,
    output logic        o_stale
);
    localparam int                 CNT_W       = $clog2(SETTLE_CYCLES + 1);
    localparam int                 WD_W        = 20;
    localparam logic [CNT_W-1:0]   SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WD_W-1:0]    WD_MAX      = '1;
    localparam logic [WD_W-1:0]    WD_LIMIT    = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_CAPTURE} state_t;

    state_t                 state_reg, state_next;
    logic [CNT_W-1:0]       settle_cnt_reg;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   sync_delay_reg;
    logic                   flag_edge;

    logic [15:0]            words      [3];
    logic [15:0]            pend_reg   [3];
    logic [15:0]            ctrl_reg   [3];
    logic [2:0]             word_ok;
    logic                   pending_valid_reg;
    logic                   update_reg;
    logic                   overrun_reg;
    logic [7:0]             frame_errors_reg;
    logic [WD_W-1:0]        wd_reg, wd_next;
    logic                   stale_reg;

    // FSM decoded controls
    logic                   settle_load;
    logic                   settle_overrun;
    logic                   capture;
    logic                   accept;
    logic                   reject;
    logic                   apply;

    assign words[0] = i_data0;
    assign words[1] = i_data1;
    assign words[2] = i_data2;

    // A word is in range when no bit at or above ADC_BITS is set.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_range
            assign word_ok[gi] = ~|(words[gi] >> ADC_BITS);
        end
    endgenerate

    // Flag synchroniser plus rising-edge detect on the last stage.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            sync_reg       <= '0;
            sync_delay_reg <= 1'b0;
        end else begin
            sync_reg       <= {sync_reg[SYNC_STAGES-2:0], i_data_received};
            sync_delay_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign flag_edge = sync_reg[SYNC_STAGES-1] & ~sync_delay_reg;

    // FSM: state register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state. A fresh edge during SETTLE restarts the window.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (flag_edge) state_next = ST_SETTLE;
            ST_SETTLE:  if (!flag_edge && settle_cnt_reg == '0) state_next = ST_CAPTURE;
            ST_CAPTURE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        settle_load    = 1'b0;
        settle_overrun = 1'b0;
        capture        = 1'b0;
        case (state_reg)
            ST_IDLE:    settle_load = flag_edge;
            ST_SETTLE: begin
                settle_load    = flag_edge;
                settle_overrun = flag_edge;
            end
            ST_CAPTURE: capture = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            settle_cnt_reg <= '0;
        end else if (settle_load) begin
            settle_cnt_reg <= SETTLE_LOAD;
        end else if (state_reg == ST_SETTLE && settle_cnt_reg != '0) begin
            settle_cnt_reg <= settle_cnt_reg - CNT_W'(1);
        end
    end

    assign accept = capture & (&word_ok);
    assign reject = capture & ~(&word_ok);
    assign apply  = i_sample_tick & pending_valid_reg;

    // Watchdog: saturating, cleared by every accepted frame. o_stale is
    // derived from the next count so it rises on the edge the count
    // reaches the limit and drops on the edge of an accepted capture.
    always_comb begin
        wd_next = wd_reg;
        if (accept) begin
            wd_next = '0;
        end else if (wd_reg != WD_MAX) begin
            wd_next = wd_reg + WD_W'(1);
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 3; i++) begin
                pend_reg[i] <= '0;
                ctrl_reg[i] <= '0;
            end
            pending_valid_reg <= 1'b0;
            update_reg        <= 1'b0;
            overrun_reg       <= 1'b0;
            frame_errors_reg  <= '0;
            wd_reg            <= '0;
            stale_reg         <= 1'b0;
        end else begin
            update_reg <= apply;
            wd_reg     <= wd_next;
            stale_reg  <= (wd_next >= WD_LIMIT);

            // The tick consumes the old frame before a same-cycle capture
            // refills the buffer.
            if (apply) begin
                for (int i = 0; i < 3; i++) ctrl_reg[i] <= pend_reg[i];
            end
            if (accept) begin
                for (int i = 0; i < 3; i++) pend_reg[i] <= words[i];
                pending_valid_reg <= 1'b1;
            end else if (apply) begin
                pending_valid_reg <= 1'b0;
            end

            // Events take priority over a same-cycle clear.
            if (settle_overrun || (accept && pending_valid_reg && !i_sample_tick)) begin
                overrun_reg <= 1'b1;
            end else if (i_clear_flags) begin
                overrun_reg <= 1'b0;
            end

            if (reject) begin
                if (i_clear_flags) begin
                    frame_errors_reg <= 8'd1;
                end else if (frame_errors_reg != 8'hFF) begin
                    frame_errors_reg <= frame_errors_reg + 8'd1;
                end
            end else if (i_clear_flags) begin
                frame_errors_reg <= '0;
            end
        end
    end

    assign o_ctrl0        = ctrl_reg[0];
    assign o_ctrl1        = ctrl_reg[1];
    assign o_ctrl2        = ctrl_reg[2];
    assign o_update       = update_reg;
    assign o_pending      = pending_valid_reg;
    assign o_overrun      = overrun_reg;
    assign o_frame_errors = frame_errors_reg;
    assign o_stale        = stale_reg;

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Testbench for adc_frame_scheduler. Directed scenarios followed by random
// frames; every cycle all outputs are compared with a reference model that
// works from frame arrival times (capture due a fixed number of edges after
// the flag is first sampled high) and the apply/overrun/error/watchdog rules.
module tb_adc_frame_scheduler;
    localparam int SYNC_STAGES    = 2;
    localparam int SETTLE_CYCLES  = 4;
    localparam int ADC_BITS       = 12;
    localparam int TIMEOUT_CYCLES = 100;
    localparam int CAP_OFS        = SYNC_STAGES + SETTLE_CYCLES + 1;
    localparam int WD_MAX         = (1 << 20) - 1;
    localparam int HOLD           = 9;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_data_received = 1'b0;
    logic [15:0] i_data0 = '0;
    logic [15:0] i_data1 = '0;
    logic [15:0] i_data2 = '0;
    logic        i_sample_tick = 1'b0;
    logic        i_clear_flags = 1'b0;
    logic [15:0] o_ctrl0, o_ctrl1, o_ctrl2;
    logic        o_update, o_pending, o_overrun, o_stale;
    logic [7:0]  o_frame_errors;

    always #5 i_clock = ~i_clock;

    adc_frame_scheduler #(
        .SYNC_STAGES   (SYNC_STAGES),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .ADC_BITS      (ADC_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_data_received(i_data_received),
        .i_data0        (i_data0),
        .i_data1        (i_data1),
        .i_data2        (i_data2),
        .i_sample_tick  (i_sample_tick),
        .i_clear_flags  (i_clear_flags),
        .o_ctrl0        (o_ctrl0),
        .o_ctrl1        (o_ctrl1),
        .o_ctrl2        (o_ctrl2),
        .o_update       (o_update),
        .o_pending      (o_pending),
        .o_overrun      (o_overrun),
        .o_frame_errors (o_frame_errors),
        .o_stale        (o_stale)
    );

    int tests = 0;
    int failures = 0;
    int n = 0;
    bit flag_prev = 1'b0;

    // Reference model state
    int m_ctrl [3];
    int m_pend [3];
    int s_data [3];
    bit m_upd, m_pv, m_ovr, m_stale;
    int m_err, m_wd;
    bit s_valid, e_valid;
    int s_cyc, e_cyc;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, n);
        end
    endtask

    task automatic model_step(input bit rs, input bit rise, input bit tk, input bit cl);
        bit pv_old, ok, in_range;
        if (rs) begin
            for (int i = 0; i < 3; i++) begin
                m_ctrl[i] = 0;
                m_pend[i] = 0;
            end
            m_upd = 0; m_pv = 0; m_ovr = 0; m_err = 0; m_wd = 0; m_stale = 0;
            s_valid = 0; e_valid = 0;
            return;
        end
        if (rise) begin
            // A second frame arriving before the first is captured loses the first.
            if (s_valid) begin
                e_valid = 1;
                e_cyc   = n + SYNC_STAGES;
            end
            s_valid   = 1;
            s_cyc     = n + CAP_OFS;
            s_data[0] = int'(i_data0);
            s_data[1] = int'(i_data1);
            s_data[2] = int'(i_data2);
        end
        m_upd = 0;
        ok = 0;
        pv_old = m_pv;
        if (cl) begin
            m_ovr = 0;
            m_err = 0;
        end
        if (e_valid && n == e_cyc) begin
            m_ovr = 1;
            e_valid = 0;
        end
        if (tk && pv_old) begin
            m_ctrl = m_pend;
            m_upd = 1;
            m_pv = 0;
        end
        if (s_valid && n == s_cyc) begin
            s_valid = 0;
            in_range = (s_data[0] < (1 << ADC_BITS)) && (s_data[1] < (1 << ADC_BITS))
                       && (s_data[2] < (1 << ADC_BITS));
            if (in_range) begin
                if (pv_old && !tk) m_ovr = 1;
                m_pend = s_data;
                m_pv = 1;
                ok = 1;
            end else if (m_err < 255) begin
                m_err++;
            end
        end
        if (ok) m_wd = 0;
        else if (m_wd < WD_MAX) m_wd++;
        m_stale = (m_wd >= TIMEOUT_CYCLES);
    endtask

    // One clock: capture inputs, advance model on the edge, compare 1 ns later,
    // return at the falling edge ready for the next drive.
    task automatic cycle();
        bit rise, tk, cl, rs;
        rise = (i_data_received === 1'b1) && !flag_prev;
        flag_prev = i_data_received;
        tk = i_sample_tick;
        cl = i_clear_flags;
        rs = i_reset;
        @(posedge i_clock);
        n++;
        model_step(rs, rise, tk, cl);
        #1;
        chk("ctrl0", int'(o_ctrl0), m_ctrl[0]);
        chk("ctrl1", int'(o_ctrl1), m_ctrl[1]);
        chk("ctrl2", int'(o_ctrl2), m_ctrl[2]);
        chk("update", int'(o_update), int'(m_upd));
        chk("pending", int'(o_pending), int'(m_pv));
        chk("overrun", int'(o_overrun), int'(m_ovr));
        chk("frame_errors", int'(o_frame_errors), m_err);
        chk("stale", int'(o_stale), int'(m_stale));
        @(negedge i_clock);
    endtask

    task automatic idle(input int cnt, input bit rnd);
        for (int k = 0; k < cnt; k++) begin
            i_sample_tick = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
            i_clear_flags = rnd ? ($urandom_range(0, 63) == 0) : 1'b0;
            cycle();
        end
        i_sample_tick = 1'b0;
        i_clear_flags = 1'b0;
    endtask

    task automatic pulse_tick();
        i_sample_tick = 1'b1;
        cycle();
        i_sample_tick = 1'b0;
    endtask

    task automatic pulse_clear();
        i_clear_flags = 1'b1;
        cycle();
        i_clear_flags = 1'b0;
    endtask

    // Offset k=CAP_OFS of the hold loop is the capture edge; tick_k selects
    // where a directed tick lands (-1 for none).
    task automatic send_frame(input logic [15:0] d0, input logic [15:0] d1,
                              input logic [15:0] d2, input int tick_k, input bit rnd);
        i_data0 = d0;
        i_data1 = d1;
        i_data2 = d2;
        i_data_received = 1'b1;
        $display("[TB] cycle %0d frame %04h %04h %04h", n, d0, d1, d2);
        for (int k = 0; k < HOLD; k++) begin
            i_sample_tick = rnd ? ($urandom_range(0, 15) == 0) : (k == tick_k);
            i_clear_flags = rnd ? ($urandom_range(0, 63) == 0) : 1'b0;
            cycle();
        end
        i_data_received = 1'b0;
        i_sample_tick = 1'b0;
        i_clear_flags = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        logic [15:0] d [3];
        int r;

        // Reset state
        i_reset = 1'b1;
        repeat (3) cycle();
        i_reset = 1'b0;

        // Watchdog with no frames: o_stale rises once 100 cycles elapse
        idle(110, 1'b0);

        // Single frame, tick 20 cycles later
        send_frame(16'h0123, 16'h0456, 16'h0789, -1, 1'b0);
        idle(20, 1'b0);
        pulse_tick();
        idle(3, 1'b0);

        // Two frames without a tick: overrun, newer frame applied
        send_frame(16'h0010, 16'h0001, 16'h0002, -1, 1'b0);
        send_frame(16'h0020, 16'h0001, 16'h0002, -1, 1'b0);
        pulse_tick();
        idle(3, 1'b0);

        // Out-of-range word: rejected, then clear flags
        send_frame(16'h0111, 16'h1000, 16'h0222, -1, 1'b0);
        idle(3, 1'b0);
        pulse_clear();
        idle(2, 1'b0);

        // Boundary: all words at the largest legal value
        send_frame(16'h0FFF, 16'h0FFF, 16'h0FFF, -1, 1'b0);
        pulse_tick();
        idle(2, 1'b0);

        // Tick during capture: A applied, B left pending, no overrun
        send_frame(16'h0AAA, 16'h0AAB, 16'h0AAC, -1, 1'b0);
        send_frame(16'h0BBA, 16'h0BBB, 16'h0BBC, CAP_OFS, 1'b0);
        idle(3, 1'b0);
        pulse_tick();
        idle(2, 1'b0);

        // Reset during SETTLE abandons the frame; next frame is normal
        i_data0 = 16'h0321;
        i_data1 = 16'h0654;
        i_data2 = 16'h0987;
        i_data_received = 1'b1;
        repeat (4) cycle();
        i_reset = 1'b1;
        i_data_received = 1'b0;
        repeat (2) cycle();
        i_reset = 1'b0;
        idle(3, 1'b0);
        send_frame(16'h0042, 16'h0043, 16'h0044, -1, 1'b0);
        pulse_tick();
        idle(2, 1'b0);

        // New edge during SETTLE: overrun, the later frame is captured
        pulse_clear();
        i_data0 = 16'h0555;
        i_data1 = 16'h0556;
        i_data2 = 16'h0557;
        i_data_received = 1'b1;
        cycle();
        i_data_received = 1'b0;
        cycle();
        send_frame(16'h0666, 16'h0667, 16'h0668, -1, 1'b0);
        pulse_tick();
        idle(2, 1'b0);
        pulse_clear();

        // Random frames, ticks and clears
        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < 3; i++) d[i] = 16'($urandom_range(0, 4095));
            r = $urandom_range(0, 7);
            if (r == 0) d[$urandom_range(0, 2)] = 16'($urandom_range(4096, 65535));
            else if (r == 1) d[$urandom_range(0, 2)] = 16'h0FFF;
            else if (r == 2) d[$urandom_range(0, 2)] = 16'h1000;
            send_frame(d[0], d[1], d[2], -1, 1'b1);
            idle(($urandom_range(0, 9) == 0) ? 120 : $urandom_range(0, 8), 1'b1);
        end

        // Error counter saturation, then clear
        pulse_clear();
        for (int f = 0; f < 260; f++) begin
            send_frame(16'h0001, 16'h0002, 16'hF000, -1, 1'b0);
        end
        idle(2, 1'b0);
        pulse_clear();
        idle(2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end
endmodule

// File: doc/adc_frame_scheduler.md
Name: adc_frame_scheduler

Overview:
Consumes the three 16-bit ADC control words delivered by the SPI slave receiver and moves them safely into the i_clock domain. It resynchronises the receiver's frame-done flag, waits a settle window, range-checks and captures the frame into a pending buffer, then applies it to the synth core only on an audio sample tick. Control values therefore never change mid-sample. It also reports overrun, rejected frames and a stale-link watchdog to the rest of the design.

Parameters:
SYNC_STAGES, 2, flip-flops in the i_data_received synchroniser (min 2)
SETTLE_CYCLES, 4, i_clock cycles to wait after edge detect before sampling the data words (min 1)
ADC_BITS, 12, valid ADC width; any word with a nonzero bit at or above ADC_BITS is out of range
TIMEOUT_CYCLES, 1000000, cycles without an accepted frame before o_stale asserts

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_data_received  in  1  frame-done flag from the SPI receiver, asynchronous to i_clock
i_data0  in  16  word 0 from the SPI receiver, valid while the flag is high
i_data1  in  16  word 1
i_data2  in  16  word 2
i_sample_tick  in  1  one-cycle strobe per audio sample
i_clear_flags  in  1  one-cycle pulse; clears o_overrun and o_frame_errors
o_ctrl0  out  16  applied control word 0
o_ctrl1  out  16  applied control word 1
o_ctrl2  out  16  applied control word 2
o_update  out  1  one-cycle pulse on the cycle o_ctrl* take new values
o_pending  out  1  a captured frame is waiting for a sample tick
o_overrun  out  1  sticky; a frame was lost or overwritten
o_frame_errors  out  8  saturating count of rejected frames
o_stale  out  1  no accepted frame within TIMEOUT_CYCLES

Behaviour:
- Reset clears every output to 0, the synchroniser, the FSM (IDLE), the pending buffer, pending_valid and the watchdog counter. Reset applied mid-SETTLE or mid-CAPTURE abandons the frame without applying it.
- i_data_received passes through SYNC_STAGES flops. Edge detect = last stage high AND a one-cycle-delayed copy low. i_data0..2 are sampled only in CAPTURE and are not synchronised.
- FSM states and transitions:
  - IDLE -> SETTLE on edge detect. The settle counter loads SETTLE_CYCLES-1.
  - SETTLE: decrement the counter; go to CAPTURE when it is 0. A new edge in SETTLE sets o_overrun and reloads the counter.
  - CAPTURE, one cycle: if all three words are below 2^ADC_BITS, load the pending buffer, set pending_valid and clear the watchdog. If pending_valid was already 1 and no tick in this cycle consumes it, set o_overrun (the newer frame wins). If any word is out of range, discard the whole frame and increment o_frame_errors, saturating at 255. The pending buffer is untouched on rejection. Next state is IDLE.
- Latency: pending_valid/o_pending rises SYNC_STAGES+SETTLE_CYCLES+2 clock edges after the first edge that samples i_data_received high. This is 8 with default parameters.
- Apply: when i_sample_tick=1 and pending_valid=1, on the next edge o_ctrl* <= pending buffer, o_update=1 for that one cycle, and pending_valid clears. A tick with pending_valid=0 does nothing.
- Tick and CAPTURE in the same cycle:
  - The tick applies the old pending frame, if any.
  - The new frame then becomes pending.
  - No overrun is flagged.
- Watchdog:
  - 20-bit saturating counter, incrementing every cycle.
  - Cleared to 0 on each accepted CAPTURE.
  - o_stale = (counter >= TIMEOUT_CYCLES), registered; it is 0 from reset until the timeout first elapses.
- i_clear_flags zeroes o_overrun and o_frame_errors. An event in the same cycle wins, giving o_overrun=1 and o_frame_errors=1.

Test Plan:
- One frame with data 0x0123/0x0456/0x0789 and no ticks: o_pending rises 8 edges after the flag is sampled high. The tick 20 cycles later gives o_ctrl*=0x0123/0x0456/0x0789 and exactly one o_update pulse; o_overrun=0.
- Two frames (0x0010 then 0x0020 on word 0) with no tick between: o_overrun=1, and the next tick applies 0x0020 only.
- Frame with i_data1=0x1000: frame rejected, o_frame_errors=1, o_ctrl* and o_pending unchanged. A following i_clear_flags returns the counter to 0.
- i_sample_tick held in the CAPTURE cycle with a prior pending frame A and new frame B: A is applied with o_update, B stays pending (o_pending=1), o_overrun=0.
- TIMEOUT_CYCLES=100 override with no frames: o_stale=1 at cycle 100. A valid frame drops o_stale the cycle after CAPTURE.
- i_reset asserted during SETTLE: o_pending stays 0, all outputs 0, and the next frame completes normally with 8-edge latency.
